// File: rtl/nic.sv
// Memory-mapped NIC between the processor data port and one ring-router node.
// One-packet receive buffer and one-packet transmit buffer, each with a full flag.
module nic #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:1]        addr,
   input  logic [0:DATA_W-1] d_in,
   output logic [0:DATA_W-1] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [0:DATA_W-1] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [0:DATA_W-1] net_do,
   input  logic              net_polarity
);

   localparam logic [0:1] ADDR_IN_BUF  = 2'b00;
   localparam logic [0:1] ADDR_IN_STAT = 2'b01;
   localparam logic [0:1] ADDR_OUT_BUF = 2'b10;
   localparam logic [0:1] ADDR_OUT_STAT = 2'b11;

   logic [0:DATA_W-1] in_buf;
   logic              in_full;
   logic [0:DATA_W-1] out_buf;
   logic              out_full;

   logic              cpu_rd;
   logic              cpu_wr;
   logic              recv;
   logic              drain;
   logic              load;
   logic              send;
   logic [0:DATA_W-1] rd_data;

   assign cpu_rd = nicEn & ~nicWrEn;
   assign cpu_wr = nicEn & nicWrEn;

   // All decisions use flag values as of the edge; recv/drain and load/send
   // are therefore mutually exclusive.
   assign recv  = net_si & ~in_full;
   assign drain = cpu_rd & (addr == ADDR_IN_BUF) & in_full;
   assign load  = cpu_wr & (addr == ADDR_OUT_BUF) & ~out_full;
   assign send  = out_full & net_ro & (out_buf[0] == net_polarity);

   assign net_ri = ~in_full;

   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_IN_BUF:   rd_data = in_buf;
         ADDR_IN_STAT:  rd_data = {{(DATA_W-1){1'b0}}, in_full};
         ADDR_OUT_STAT: rd_data = {{(DATA_W-1){1'b0}}, out_full};
         default:       rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_buf   <= '0;
         in_full  <= 1'b0;
         out_buf  <= '0;
         out_full <= 1'b0;
         d_out    <= '0;
         net_so   <= 1'b0;
         net_do   <= '0;
      end else begin
         if (recv) begin
            in_buf <= net_di;
         end
         if (recv) begin
            in_full <= 1'b1;
         end else if (drain) begin
            in_full <= 1'b0;
         end

         if (load) begin
            out_buf <= d_in;
         end
         if (load) begin
            out_full <= 1'b1;
         end else if (send) begin
            out_full <= 1'b0;
         end

         net_so <= send;
         if (send) begin
            net_do <= out_buf;
         end

         if (cpu_rd) begin
            d_out <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_nic.sv
// Directed bench for nic: receive, CPU read/write, VC-gated transmit, reset.
module tb_nic;

   logic        clk = 1'b0;
   logic        reset;
   logic [0:1]  addr;
   logic [0:63] d_in;
   logic [0:63] d_out;
   logic        nicEn;
   logic        nicWrEn;
   logic        net_si;
   logic        net_ri;
   logic [0:63] net_di;
   logic        net_so;
   logic        net_ro;
   logic [0:63] net_do;
   logic        net_polarity;

   int total = 0;
   int bad   = 0;

   nic #(.DATA_W(64)) dut (
      .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [1:0] a);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
      tick();
      nicEn = 1'b0;
   endtask

   task automatic cpu_write(input logic [63:0] v);
      nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = v;
      tick();
      nicEn = 1'b0; nicWrEn = 1'b0;
   endtask

   task automatic router_send(input logic [63:0] v);
      net_si = 1'b1; net_di = v;
      tick();
      net_si = 1'b0;
   endtask

   initial begin
      reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
      net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
      #1;
      tick(); tick();
      check("rst_net_ri", 64'(net_ri), 64'd1);
      check("rst_net_so", 64'(net_so), 64'd0);
      check("rst_d_out", d_out, 64'd0);
      check("rst_net_do", net_do, 64'd0);
      reset = 1'b0;

      cpu_read(2'b01); check("idle_stat01", d_out, 64'd0);
      cpu_read(2'b11); check("idle_stat11", d_out, 64'd0);

      // receive one packet and drain it
      router_send(64'h8000_0000_0000_00AB);
      check("rx_net_ri_low", 64'(net_ri), 64'd0);
      cpu_read(2'b01); check("rx_stat01", d_out, 64'd1);
      cpu_read(2'b00); check("rx_data", d_out, 64'h8000_0000_0000_00AB);
      check("rx_net_ri_high", 64'(net_ri), 64'd1);
      cpu_read(2'b01); check("rx_stat01_clr", d_out, 64'd0);

      // VC 0 packet with matching polarity
      net_ro = 1'b1; net_polarity = 1'b0;
      cpu_write(64'h0000_0000_0000_1234);
      check("tx_so_wr_edge", 64'(net_so), 64'd0);
      tick();
      check("tx_so_pulse", 64'(net_so), 64'd1);
      check("tx_do", net_do, 64'h0000_0000_0000_1234);
      tick();
      check("tx_so_one_cycle", 64'(net_so), 64'd0);
      cpu_read(2'b11); check("tx_stat11", d_out, 64'd0);

      // VC 1 packet held back until polarity flips; second write dropped
      cpu_write(64'h8000_0000_0000_0001);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("vc_hold_%0d", i), 64'(net_so), 64'd0);
      end
      cpu_read(2'b11); check("vc_stat11_full", d_out, 64'd1);
      cpu_write(64'hDEAD_BEEF_0000_0002);
      net_polarity = 1'b1;
      tick();
      check("vc_so_pulse", 64'(net_so), 64'd1);
      check("vc_do", net_do, 64'h8000_0000_0000_0001);
      tick();
      check("vc_so_off", 64'(net_so), 64'd0);
      cpu_read(2'b11); check("vc_drop_stat11", d_out, 64'd0);
      tick(); tick();
      check("vc_drop_net_do", net_do, 64'h8000_0000_0000_0001);
      check("vc_drop_no_so", 64'(net_so), 64'd0);
      net_polarity = 1'b0;

      // overrun while full is ignored; new packet lands after drain
      router_send(64'h0000_0000_0000_0011);
      net_si = 1'b1; net_di = 64'h0000_0000_0000_0022;
      tick(); tick();
      check("ovr_net_ri", 64'(net_ri), 64'd0);
      cpu_read(2'b00); check("ovr_old_data", d_out, 64'h0000_0000_0000_0011);
      check("ovr_net_ri_free", 64'(net_ri), 64'd1);
      tick();
      net_si = 1'b0;
      check("ovr_accept", 64'(net_ri), 64'd0);
      cpu_read(2'b00); check("ovr_new_data", d_out, 64'h0000_0000_0000_0022);
      cpu_read(2'b00); check("stale_read", d_out, 64'h0000_0000_0000_0022);
      check("stale_net_ri", 64'(net_ri), 64'd1);
      cpu_read(2'b10); check("read_10_zero", d_out, 64'd0);
      cpu_read(2'b01);
      tick();
      check("d_out_hold", d_out, 64'd0);

      // fill both buffers, then reset with a send that would otherwise fire
      net_ro = 1'b0;
      router_send(64'h0000_0000_0000_0033);
      cpu_write(64'h8000_0000_0000_0005);
      cpu_read(2'b01); check("pre_rst_stat01", d_out, 64'd1);
      net_ro = 1'b1; net_polarity = 1'b1; reset = 1'b1;
      tick();
      check("mid_rst_net_ri", 64'(net_ri), 64'd1);
      check("mid_rst_net_so", 64'(net_so), 64'd0);
      check("mid_rst_d_out", d_out, 64'd0);
      reset = 1'b0;
      tick();
      check("post_rst_no_send", 64'(net_so), 64'd0);
      cpu_read(2'b01); check("post_rst_stat01", d_out, 64'd0);
      cpu_read(2'b11); check("post_rst_stat11", d_out, 64'd0);
      cpu_read(2'b00); check("post_rst_in_buf", d_out, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nic.md
# nic

Network interface controller between the `cmp` processor's data-memory port and one node of the NOC ring router. It is memory-mapped: the CPU reaches it with ordinary load/store traffic on its memory interface. It holds one 64-bit input buffer for packets delivered by the router and one 64-bit output buffer for packets injected by the CPU. Each buffer has a full flag that the CPU polls through a status register.

## Interface
Parameters:
- `DATA_W`, 64, packet and CPU data width; the RTL requires 64.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  [0:1]  register select.
  - 00: input buffer (read).
  - 01: input status (read).
  - 10: output buffer (write).
  - 11: output status (read).
- `d_in`  in  [0:63]  CPU store data.
- `d_out`  out  [0:63]  CPU load data, registered.
- `nicEn`  in  1  access strobe.
- `nicWrEn`  in  1  1 = write, 0 = read; ignored when `nicEn`=0.
- `net_si`  in  1  router is sending a packet into the NIC.
- `net_ri`  out  1  NIC ready to receive; equals the inverse of the input-full flag.
- `net_di`  in  [0:63]  packet from the router.
- `net_so`  out  1  NIC sending a packet to the router, registered.
- `net_ro`  in  1  router ready to accept.
- `net_do`  out  [0:63]  packet to the router, registered.
- `net_polarity`  in  1  current router virtual-channel phase.

## Operation
State:
- `in_buf` and `in_full` hold the received packet and its flag.
- `out_buf` and `out_full` hold the packet waiting to be injected and its flag.
- Big-endian bit numbering. Packet bit 0 is the VC bit.

Reset values:
- `in_full`=0, `out_full`=0, `in_buf`=0, `out_buf`=0.
- `d_out`=0, `net_so`=0, `net_do`=0.
- `net_ri`=1.

Receive path:
- A packet is accepted at a clock edge when `net_si`=1 and `in_full`=0. On that edge `in_buf`←`net_di` and `in_full`←1.
- When `in_full`=1, `net_ri`=0. If the router asserts `net_si` anyway, the packet is ignored and `in_buf` is unchanged.

CPU read (`nicEn`=1, `nicWrEn`=0):
- `addr`=00: `d_out`←`in_buf`. If `in_full`=1, `in_full`←0 on the same edge. A read while empty returns stale `in_buf` and changes no state.
- `addr`=01: `d_out`←{63'b0, `in_full`}.
- `addr`=11: `d_out`←{63'b0, `out_full`}.
- `addr`=10: `d_out`←0.
- `d_out` holds its value on cycles with no read.

CPU write (`nicEn`=1, `nicWrEn`=1):
- `addr`=10 with `out_full`=0: `out_buf`←`d_in`, `out_full`←1.
- A write while `out_full`=1 is dropped; software must poll status first.
- Writes to any other address are ignored.

Transmit path:
- A send fires at a clock edge when `out_full`=1, `net_ro`=1 and `out_buf[0]`==`net_polarity`.
- On that edge: `net_do`←`out_buf`, `net_so`←1, `out_full`←0.
- On every other edge `net_so`←0. `net_do` holds its last value.

## Timing
- Read latency is 1 cycle: data appears on `d_out` the cycle after the strobe, matching the processor's data-memory timing.
- Write-to-status latency is 1 cycle: a status read issued in the cycle after a write returns the updated flag.
- Minimum write-to-send latency is 1 cycle: write at edge N, earliest `net_so`=1 after edge N+1.
- `net_so` is a one-cycle pulse per packet. Back-to-back sends are impossible, because `out_full` must be refilled in between.
- Write and send at the same edge: the flag is evaluated as of the edge (`out_full`=1), so the write is dropped and the send proceeds.
- Receive and read-00 at the same edge: impossible when full, since `net_ri`=0. When empty, the read returns stale data and the receive completes.
- Reset asserted mid-operation clears both buffers and flags at the next edge, discarding any buffered packet. No send or receive occurs on that edge.
- `net_ri` is combinational from `in_full` only; there is no combinational path from `net_si` to `net_ri`.

## Test plan
- Reset, then idle: `net_ri`=1, `net_so`=0. Status reads at 01 and 11 return 0.
- Router sends 0x8000_0000_0000_00AB with `net_si`=1:
  - `net_ri`=0 next cycle, and a status-01 read returns 1.
  - A read at 00 returns 0x8000_0000_0000_00AB one cycle later; `in_full` clears and `net_ri`=1.
- CPU writes 0x0000_0000_0000_1234 to 10 with `net_ro`=1, `net_polarity`=0:
  - `net_so` pulses once, with `net_do`=0x0000_0000_0000_1234, one cycle after the write.
  - Status 11 then reads 0.
- Write 0x8000_0000_0000_0001 (VC=1) with `net_polarity`=0 for 5 cycles: no send.
  - Flip polarity to 1: `net_so` pulses the next cycle.
  - A second write issued while full is dropped; `net_do` never shows its value.
- `in_full`=1 and router holds `net_si`=1 with new data: `in_buf` is unchanged. After a CPU read drains the buffer, the new data is accepted.
- Reset asserted while both buffers are full: next cycle both status flags are 0, `net_ri`=1, `net_so`=0, `d_out`=0.
